// File: rtl/ram_datos_pkg.sv
// Shared types and helpers for the synchronous data RAM.
//   state_t     : sweep FSM encoding (ST_INIT zero-fills, ST_RUN serves accesses)
//   byte_lanes  : number of 8-bit lanes in a word of a given width
//   byte_merge  : overlays the masked bytes of a new word onto an old word
package ram_datos_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // byte_merge works on a fixed wide word; callers zero-extend and truncate.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_BYTE_LANES = MAX_DATA_WIDTH / 8;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BYTE_LANES-1:0] mask
    );
        logic [MAX_DATA_WIDTH-1:0] w;
        w = old_word;
        for (int k = 0; k < MAX_BYTE_LANES; k++)
            if (mask[k]) w[8*k +: 8] = new_word[8*k +: 8];
        return w;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Read-return pipeline: LATENCY stages of {valid, err, data}.
// Data in a stage only moves when the stage feeding it is valid, so the last
// stage holds the most recent returned word between reads.
//   Clock, Reset   : clock, asynchronous active-high clear of all stages
//   in_vld/in_err/in_data    : accepted read entering the pipe
//   out_vld/out_err/out_data : read result after LATENCY cycles
module ram_read_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  in_vld,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    output logic                  out_err,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]                 vld_pipe;
    logic [LATENCY-1:0]                 err_pipe;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            err_pipe[0] <= in_err;
            if (in_vld) dat_pipe[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
                if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign out_vld  = vld_pipe[LATENCY-1];
    assign out_err  = err_pipe[LATENCY-1];
    assign out_data = dat_pipe[LATENCY-1];

endmodule

// File: rtl/ram_datos_sync.sv
// Synchronous data RAM: one write port with byte lanes, one pipelined read
// port, write-first bypass on same-address collisions, out-of-range flagging
// and an optional zero-fill sweep after reset.
//   Clock, Reset        : rising-edge clock, asynchronous active-high reset
//   iMemEnable          : global access enable
//   iWriteDataEnable, iByteEnable, iWriteDataAddress, iDataMemIn : write port
//   iReadDataEnable, iReadDataAddress                             : read port
//   oDataMemOut, oDataValid : read data (held between reads) and its strobe
//   oReady              : accesses are accepted
//   oAddrError          : pulse for an access to an address >= MEM_SIZE
module ram_datos_sync
    import ram_datos_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int MEM_SIZE      = 1024,
    parameter int READ_LATENCY  = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iMemEnable,
    input  logic                    iWriteDataEnable,
    input  logic [DATA_WIDTH/8-1:0] iByteEnable,
    input  logic [ADDR_WIDTH-1:0]   iWriteDataAddress,
    input  logic [DATA_WIDTH-1:0]   iDataMemIn,
    input  logic                    iReadDataEnable,
    input  logic [ADDR_WIDTH-1:0]   iReadDataAddress,
    output logic [DATA_WIDTH-1:0]   oDataMemOut,
    output logic                    oDataValid,
    output logic                    oReady,
    output logic                    oAddrError
);

    localparam int BYTE_LANES = byte_lanes(DATA_WIDTH);
    // Index width matches the array depth exactly; range checks use the full address.
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(MEM_SIZE - 1);
    localparam state_t              RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    state_t           state;
    logic             ready;
    logic [IDX_W-1:0] sweep_cnt;

    logic                  wr_ok, rd_ok;
    logic                  wr_in_range, rd_in_range, hit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_err_q, pipe_err;

    always_comb begin
        wr_ok       = ready && iMemEnable && iWriteDataEnable;
        rd_ok       = ready && iMemEnable && iReadDataEnable;
        wr_in_range = {1'b0, iWriteDataAddress} < MEM_LIMIT;
        rd_in_range = {1'b0, iReadDataAddress} < MEM_LIMIT;
        wr_idx      = iWriteDataAddress[IDX_W-1:0];
        rd_idx      = iReadDataAddress[IDX_W-1:0];
        hit         = wr_ok && wr_in_range && (iWriteDataAddress == iReadDataAddress);
        // Write-first: a same-cycle write to the read address is merged into the returned word.
        rd_word = '0;
        if (rd_in_range) begin
            if (hit)
                rd_word = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem[rd_idx]),
                                                 MAX_DATA_WIDTH'(iDataMemIn),
                                                 MAX_BYTE_LANES'(iByteEnable)));
            else
                rd_word = mem[rd_idx];
        end
    end

    // Storage has no reset; contents are only cleared by the sweep.
    always_ff @(posedge Clock) begin
        if (state == ST_INIT) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_ok && wr_in_range) begin
            for (int k = 0; k < BYTE_LANES; k++)
                if (iByteEnable[k]) mem[wr_idx][8*k +: 8] <= iDataMemIn[8*k +: 8];
        end
    end

    // oReady rises together with the move to RUN, i.e. in the cycle after
    // the last sweep write.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= RST_STATE;
            sweep_cnt <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_cnt <= sweep_cnt + IDX_W'(1);
                    if (sweep_cnt == LAST_IDX) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                default: ready <= 1'b1;
            endcase
        end
    end

    // A fully masked write touches nothing, so it cannot be out of range either.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) wr_err_q <= 1'b0;
        else       wr_err_q <= wr_ok && !wr_in_range && (|iByteEnable);
    end

    ram_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_read_pipe (
        .Clock    (Clock),
        .Reset    (Reset),
        .in_vld   (rd_ok),
        .in_err   (rd_ok && !rd_in_range),
        .in_data  (rd_word),
        .out_vld  (oDataValid),
        .out_err  (pipe_err),
        .out_data (oDataMemOut)
    );

    assign oReady     = ready;
    // Bad write and bad read landing on the same cycle merge into one pulse.
    assign oAddrError = wr_err_q | pipe_err;

endmodule

// File: doc/ram_datos_sync.md
Name: ram_datos_sync

Overview:
Synchronous, parametrised data RAM for the datapath: one write port and one read port on a single clock.
Adds what the previous combinational-trigger RAM lacked:
- byte-lane writes
- configurable read latency with a valid strobe
- write-first collision bypass
- out-of-range detection
- optional zero-fill sweep after reset, with a ready flag.

Parameters:
DATA_WIDTH, 8, bits per word; must be a multiple of 8.
ADDR_WIDTH, 10, address bits.
MEM_SIZE, 1024, number of words; must be <= 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from read accept to oDataValid; legal values 1 or 2.
INIT_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = skip the sweep.

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
iMemEnable  in  1  global enable; when low, no access is accepted
iWriteDataEnable  in  1  write request
iByteEnable  in  DATA_WIDTH/8  per-byte write mask; bit k covers bits [8k+7:8k]
iWriteDataAddress  in  ADDR_WIDTH  write address
iDataMemIn  in  DATA_WIDTH  write data
iReadDataEnable  in  1  read request
iReadDataAddress  in  ADDR_WIDTH  read address
oDataMemOut  out  DATA_WIDTH  read data; holds its last value between reads
oDataValid  out  1  one-cycle pulse marking oDataMemOut as new
oReady  out  1  high when the block accepts accesses
oAddrError  out  1  one-cycle pulse aligned with oDataValid, or next cycle for writes, on an address >= MEM_SIZE

Behaviour:
- Reset asserted (asynchronous):
  - oDataMemOut=0, oDataValid=0, oReady=0, oAddrError=0
  - read pipeline flushed, sweep counter=0
  - state = INIT if INIT_ON_RESET=1, else RUN
  - memory contents are not cleared by reset itself.
- FSM states INIT and RUN:
  - INIT: each cycle writes 0 to Ram[counter] and increments counter.
  - After the write of MEM_SIZE-1 the FSM goes to RUN; oReady rises the following cycle.
  - Sweep length is MEM_SIZE cycles. All requests are ignored during INIT (no valid pulse, no error pulse).
  - RUN: oReady=1.
- Reset mid-INIT restarts the sweep from 0. Reset mid-RUN drops in-flight reads; no oDataValid is emitted for them.
- Write accept condition: oReady & iMemEnable & iWriteDataEnable.
  - Ram[addr] is updated at the clock edge, only on lanes where iByteEnable=1; other lanes keep their old value.
  - iByteEnable=0 performs no update and raises no error.
- Read accept condition: oReady & iMemEnable & iReadDataEnable.
  - Address is sampled at the edge; data appears with oDataValid=1 exactly READ_LATENCY cycles later.
  - Back-to-back reads are accepted every cycle (fully pipelined).
- Collision, same cycle and same in-range address: write-first. The read returns the byte-merged new word (old bytes where iByteEnable=0).
- Read of an address written in an earlier cycle returns the updated data (no extra hazard logic needed).
- Out of range (addr >= MEM_SIZE):
  - Write is dropped; oAddrError pulses the cycle after the write edge.
  - Read returns 0 with oDataValid=1, and oAddrError pulses on the same cycle.
  - If a bad write and a bad read would both pulse oAddrError on the same cycle, it is a single pulse.
- iMemEnable low: no accesses. oDataMemOut holds, oDataValid=0. Reads already in flight still complete.
- Memory array: MEM_SIZE entries, indices 0..MEM_SIZE-1, no extra entry.

Decomposition:
- Package ram_datos_pkg:
  - state encoding (ST_INIT, ST_RUN)
  - BYTE_LANES = DATA_WIDTH/8
  - a function that merges a word under a byte mask.
- One natural sub-module: ram_read_pipe, a READ_LATENCY-deep shift of {data, valid, err}, cleared asynchronously by Reset.
- Storage array, write logic and FSM stay in the top level.

Test Plan:
(Bench configuration: DATA_WIDTH=32, ADDR_WIDTH=5, MEM_SIZE=16 unless stated.)
- Reset sweep: release Reset with INIT_ON_RESET=1. Expect oReady=0 for 16 cycles, then 1. A read of addr 7 with READ_LATENCY=1 returns 0x00000000 with oDataValid one cycle later.
- Byte lanes: write 0xAABBCCDD to addr 3 with mask 4'hF, then 0x11223344 with mask 4'b0101. Reading addr 3 returns 0xAA22CC44.
- Collision: addr 5 holds 0x0; write 0xDEADBEEF with mask 4'b1100 and read addr 5 in the same cycle. Returns 0xDEAD0000.
- Latency and streaming: READ_LATENCY=2, read addrs 0,1,2 on consecutive cycles. oDataValid is high on cycles +2, +3, +4 with data in order; oDataMemOut holds the last word afterwards.
- Range error: MEM_SIZE=12, write addr 13, then read addr 13. Memory is unchanged; the read returns 0 with oDataValid=1 and oAddrError=1 on the same cycle.
- Reset mid-operation: assert Reset while a READ_LATENCY=2 read is in flight and during sweep cycle 8. All outputs go to 0 immediately, no valid pulse follows, and the sweep restarts, taking 16 full cycles to oReady=1.
